// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall / flush / forwarding control for the F/D/E/M/W core.
// Keeps a shadow copy of the E, M and W destination/control state and
// derives hazard controls combinationally from it plus the current D inputs.
// Build option: define FORWARDING_EN to enable E-stage operand forwarding;
// without it, every RAW hit against E or M stalls D instead.
module hazard_scheduler #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [6:0]      opcodeD,
    input  logic [4:0]      rs1D,
    input  logic [4:0]      rs2D,
    input  logic [4:0]      rdD,
    input  logic            regwriteD,
    input  logic [1:0]      resultsrcD,
    input  logic            pcsrcE,
    output logic            stallF,
    output logic            stallD,
    output logic            flushD,
    output logic            flushE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic [CNTW-1:0] stallcnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       regwrite;
        logic       isload;
    } e_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } mw_state_t;

    e_state_t      e_q;
    mw_state_t     m_q, w_q;
    logic [CNTW-1:0] cnt_q;

    logic          use_rs1, use_rs2;
    logic [4:0]    rs1_u, rs2_u;
    logic          haz;

    // Producer in a stage satisfies a consumer read; x0 never matches.
    function automatic logic hit(input logic rw, input logic [4:0] rd, input logic [4:0] rs);
        return rw && (rd != 5'd0) && (rd == rs) && (rs != 5'd0);
    endfunction

    // Source-register usage from the D opcode; lui/auipc read no register,
    // so they fall in the "unknown" bucket along with everything else.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcodeD)
            OP_R, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
            OP_JAL:                   use_rs1 = 1'b0;
            default: ;
        endcase
    end

    assign rs1_u = use_rs1 ? rs1D : 5'd0;
    assign rs2_u = use_rs2 ? rs2D : 5'd0;

`ifdef FORWARDING_EN
    // Only a load in E cannot be forwarded in time; everything else forwards.
    always_comb begin
        haz = e_q.isload && (hit(e_q.regwrite, e_q.rd, rs1_u) ||
                             hit(e_q.regwrite, e_q.rd, rs2_u));
    end

    // Operand select for E: M result beats W result.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (hit(m_q.regwrite, m_q.rd, e_q.rs1))      forwardAE = 2'b10;
        else if (hit(w_q.regwrite, w_q.rd, e_q.rs1)) forwardAE = 2'b01;
        if (hit(m_q.regwrite, m_q.rd, e_q.rs2))      forwardBE = 2'b10;
        else if (hit(w_q.regwrite, w_q.rd, e_q.rs2)) forwardBE = 2'b01;
    end
`else
    // No bypass network: any producer still in E or M holds D; W is covered
    // by the write-first register file.
    always_comb begin
        haz = hit(e_q.regwrite, e_q.rd, rs1_u) || hit(e_q.regwrite, e_q.rd, rs2_u) ||
              hit(m_q.regwrite, m_q.rd, rs1_u) || hit(m_q.regwrite, m_q.rd, rs2_u);
    end

    assign forwardAE = 2'b00;
    assign forwardBE = 2'b00;

    // Shadow fields kept for state parity with the forwarding build.
    logic unused_state;
    assign unused_state = ^{e_q.rs1, e_q.rs2, e_q.isload, w_q};
`endif

    // A taken branch makes D wrong-path, so it squashes rather than stalls;
    // reset abandons any pending stall.
    assign stallF   = haz && !pcsrcE && reset_n;
    assign stallD   = stallF;
    assign flushD   = pcsrcE || !reset_n;
    assign flushE   = pcsrcE || haz || !reset_n;
    assign stallcnt = cnt_q;

    // Advance shadow pipeline and count stall cycles (saturating).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= '{rd: e_q.rd, regwrite: e_q.regwrite};
            if (flushE) e_q <= '0;
            else        e_q <= '{rd: rdD, rs1: rs1_u, rs2: rs2_u,
                                 regwrite: regwriteD, isload: (resultsrcD == 2'b01)};
            if (stallD && (cnt_q != {CNTW{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler; expectations follow the build option
// FORWARDING_EN. Counter width is shrunk to 3 bits to reach saturation quickly.
module tb_hazard_scheduler;

    localparam int CNTW = 3;
    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] NOP  = 7'b0000000;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [6:0]      opcodeD = '0;
    logic [4:0]      rs1D = '0, rs2D = '0, rdD = '0;
    logic            regwriteD = 1'b0;
    logic [1:0]      resultsrcD = '0;
    logic            pcsrcE = 1'b0;
    logic            stallF, stallD, flushD, flushE;
    logic [1:0]      forwardAE, forwardBE;
    logic [CNTW-1:0] stallcnt;

    int vectors = 0;
    int miscompares = 0;

    hazard_scheduler #(.CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D),
        .rdD(rdD), .regwriteD(regwriteD), .resultsrcD(resultsrcD), .pcsrcE(pcsrcE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallcnt(stallcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic [1:0] rsrc,
                       input logic br);
        opcodeD = op; rs1D = r1; rs2D = r2; rdD = rd;
        regwriteD = rw; resultsrcD = rsrc; pcsrcE = br;
    endtask

    // Check all outputs mid-cycle (negedge), away from the active edge.
    task automatic expo(input string tag, input logic s, input logic fd, input logic fe,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [CNTW-1:0] cnt);
        @(negedge clk);
        chk({tag, ".stallF"}, 8'(stallF), 8'(s));
        chk({tag, ".stallD"}, 8'(stallD), 8'(s));
        chk({tag, ".flushD"}, 8'(flushD), 8'(fd));
        chk({tag, ".flushE"}, 8'(flushE), 8'(fe));
        chk({tag, ".fwdA"}, 8'(forwardAE), 8'(fa));
        chk({tag, ".fwdB"}, 8'(forwardBE), 8'(fb));
        chk({tag, ".cnt"}, 8'(stallcnt), 8'(cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held: flushes forced, shadow state cleared.
        drv(NOP, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        chk("rst.flushD", 8'(flushD), 8'd1);
        chk("rst.flushE", 8'(flushE), 8'd1);
        chk("rst.cnt", 8'(stallcnt), 8'd0);
        cyc();
        reset_n = 1'b1;
        drv(NOP, 0, 0, 0, 0, 2'b00, 0);
        expo("idle", 0, 0, 0, 2'd0, 2'd0, 0);
        cyc();

`ifdef FORWARDING_EN
        drv(ADD, 1, 2, 5, 1, 2'b00, 0);  expo("f_add1", 0, 0, 0, 2'd0, 2'd0, 0); cyc();
        drv(ADD, 3, 4, 5, 1, 2'b00, 0);  expo("f_add2", 0, 0, 0, 2'd0, 2'd0, 0); cyc();
        drv(ADD, 5, 0, 9, 1, 2'b00, 0);  expo("f_add3", 0, 0, 0, 2'd0, 2'd0, 0); cyc();
        // E.rs1=5 with x5 in both M and W: M wins
        drv(ADD, 5, 5, 10, 1, 2'b00, 0); expo("f_prioM", 0, 0, 0, 2'd2, 2'd0, 0); cyc();
        // E reads x5/x5, M holds x9, W holds x5
        drv(NOP, 0, 0, 0, 0, 2'b00, 0);  expo("f_fromW", 0, 0, 0, 2'd1, 2'd1, 0); cyc();
        // load-use
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("f_lw", 0, 0, 0, 2'd0, 2'd0, 0); cyc();
        drv(ADD, 6, 1, 7, 1, 2'b00, 0);  expo("f_lwuse", 1, 0, 1, 2'd0, 2'd0, 0); cyc();
        expo("f_bubble", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        // dependent add now in E, load in W
        drv(NOP, 0, 0, 0, 0, 2'b00, 0);  expo("f_lwfwd", 0, 0, 0, 2'd1, 2'd0, 1); cyc();
        // addi ignores rs2 field
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("f_lw2", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        drv(ADDI, 1, 6, 8, 1, 2'b00, 0); expo("f_addi", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        // branch together with load-use
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("f_lw3", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        drv(ADD, 6, 1, 7, 1, 2'b00, 1);  expo("f_brstall", 0, 1, 1, 2'd0, 2'd0, 1); cyc();
        // x0
        drv(LW, 1, 0, 0, 1, 2'b01, 0);   expo("f_lwx0", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        drv(ADD, 0, 0, 7, 1, 2'b00, 0);  expo("f_x0", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        // reset in the middle of a stall
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("f_lw4", 0, 0, 0, 2'd0, 2'd0, 1); cyc();
        drv(ADD, 6, 1, 7, 1, 2'b00, 0);  expo("f_stall2", 1, 0, 1, 2'd0, 2'd0, 1);
`else
        drv(ADD, 1, 2, 5, 1, 2'b00, 0);  expo("n_add1", 0, 0, 0, 2'd0, 2'd0, 0); cyc();
        // producer in E, then in M: two stall cycles
        drv(ADD, 5, 0, 9, 1, 2'b00, 0);  expo("n_hitE", 1, 0, 1, 2'd0, 2'd0, 0); cyc();
        expo("n_hitM", 1, 0, 1, 2'd0, 2'd0, 1); cyc();
        expo("n_W", 0, 0, 0, 2'd0, 2'd0, 2); cyc();
        // addi ignores rs2 field
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("n_lw", 0, 0, 0, 2'd0, 2'd0, 2); cyc();
        drv(ADDI, 1, 6, 8, 1, 2'b00, 0); expo("n_addi", 0, 0, 0, 2'd0, 2'd0, 2); cyc();
        // branch wins over hazard (load in M)
        drv(ADD, 6, 1, 7, 1, 2'b00, 1);  expo("n_brstall", 0, 1, 1, 2'd0, 2'd0, 2); cyc();
        // rs2 hit against M
        drv(ADD, 1, 8, 7, 1, 2'b00, 0);  expo("n_rs2M", 1, 0, 1, 2'd0, 2'd0, 2); cyc();
        // x0
        drv(LW, 1, 0, 0, 1, 2'b01, 0);   expo("n_lwx0", 0, 0, 0, 2'd0, 2'd0, 3); cyc();
        drv(ADD, 0, 0, 7, 1, 2'b00, 0);  expo("n_x0", 0, 0, 0, 2'd0, 2'd0, 3); cyc();
        // reset in the middle of a stall
        drv(LW, 1, 0, 6, 1, 2'b01, 0);   expo("n_lw2", 0, 0, 0, 2'd0, 2'd0, 3); cyc();
        drv(ADD, 6, 1, 7, 1, 2'b00, 0);  expo("n_stall2", 1, 0, 1, 2'd0, 2'd0, 3);
`endif
        reset_n = 1'b0;
        #1;
        chk("midrst.flushD", 8'(flushD), 8'd1);
        chk("midrst.flushE", 8'(flushE), 8'd1);
        cyc();
        reset_n = 1'b1;
        expo("postrst", 0, 0, 0, 2'd0, 2'd0, 0);
        cyc();

        // nine load-use pairs: counter saturates at 7
        for (int i = 0; i < 9; i++) begin
            drv(LW, 1, 0, 6, 1, 2'b01, 0);
            cyc();
            drv(ADD, 6, 1, 7, 1, 2'b00, 0);
            cyc();
        end
        @(negedge clk);
        chk("sat.cnt", 8'(stallcnt), 8'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
